text_console_ctrl: RTL and testbench
====================================

Name: text_console_ctrl

Overview:
- Sequencer and arbiter for the character display write port (12-bit address {row[4:0], col[6:0]}, 16-bit data {attr[7:0], char[7:0]}).
- Shares that write port between two requesters:
  - direct CPU port writes, which always win because the CPU cannot stall;
  - a byte-stream terminal path, e.g. serial receive data.
- The terminal path interprets the bytes as text: cursor tracking, line wrap, newline, backspace and clear-screen, all expanded into display writes.

Parameters:
- COLS, 80, visible columns; cursor column range 0..COLS-1; must be ≤128.
- ROWS, 30, visible rows; cursor row range 0..ROWS-1; must be ≤32.
- ATTR, 8'h0F, attribute byte used for every console-generated write.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cpu_wr  in  1  CPU write request, single-cycle strobe
- cpu_addr  in  12  CPU write address {row, col}
- cpu_data  in  16  CPU write data {attr, char}
- in_valid  in  1  console byte valid
- in_data  in  8  console byte
- in_ready  out  1  console byte accepted when in_valid & in_ready
- dsp_wr  out  1  display write strobe
- dsp_addr  out  12  display write address
- dsp_data  out  16  display write data
- cursor_row  out  5  current cursor row
- cursor_col  out  7  current cursor column
- busy  out  1  high while a clear sweep is in progress

Behaviour:
- Reset (async):
  - dsp_wr=0, dsp_addr=0, dsp_data=0, cursor_row=0, cursor_col=0, in_ready=0, busy=1.
  - State CLEAR_ALL with sweep counter at {0,0}.
  - Reset asserted mid-operation aborts everything, and a full clear restarts on release.
- Output register:
  - dsp_* are registered, so every write appears exactly 1 cycle after its source cycle.
  - Arbitration is per cycle. If cpu_wr=1, dsp_* in the next cycle = {1, cpu_addr, cpu_data}. Otherwise, if the FSM has a pending write, that write goes out. Otherwise dsp_wr=0.
  - A CPU write is never delayed or dropped. A console write waits, holding its address and data, until a cycle with cpu_wr=0.
- FSM states: IDLE, PUT, CLEAR_ALL, CLEAR_LINE.
- IDLE:
  - in_ready=1.
  - On accept: in_ready drops the next cycle, and the byte is decoded as below.
  - 0x20..0x7E:
    - go to PUT with write {cursor, {ATTR, byte}}.
    - After the write is issued, col+1. If col was COLS-1, then col=0 and a newline is performed.
  - 0x0D: col=0; stay IDLE; no write.
  - 0x0A:
    - col=0. If row<ROWS-1, then row+1 and stay IDLE.
    - If row=ROWS-1, then row=0 and go to CLEAR_LINE for row 0.
  - 0x08:
    - If col>0: col-1, then PUT writes a space (0x20) at the new position.
    - If col=0: no effect.
  - 0x0C: go to CLEAR_ALL; the cursor homes to 0,0 at the end of the sweep.
  - Any other byte: consumed with no effect.
- PUT:
  - Holds one pending write.
  - Returns to IDLE in the cycle the write is granted.
  - If the post-write cursor update requires a newline at the bottom row, goes to CLEAR_LINE instead of IDLE.
- CLEAR_LINE:
  - Issues COLS writes of {ATTR, 0x20} to {cursor_row, 0..COLS-1}, in ascending order.
  - Each write advances only when granted, then returns to IDLE.
  - busy=0; in_ready=0.
- CLEAR_ALL:
  - Issues ROWS*COLS space writes, row-major from {0,0} to {ROWS-1, COLS-1}.
  - Each write advances only when granted.
  - At the end: cursor=0,0, busy=0, go to IDLE.
  - in_ready=0 throughout.
- Write count: with no CPU traffic, a clear costs exactly ROWS*COLS (respectively COLS) cycles. Each CPU write cycle adds one cycle.
- Scrolling: none; the display memory is write-only. The bottom-row wrap reuses row 0 after clearing it.

Optional Feature:
- Macro: TEXT_CONSOLE_TAB_EN.
- Defined: byte 0x09 sets col to the next multiple of 8, with no writes.
  - If that value is ≥COLS, col=0 and a newline is performed, with the same bottom-row rule as 0x0A.
- Undefined: 0x09 is consumed with no effect, like any other non-printable byte.

Test Plan:
- Reset release, no traffic:
  - busy=1 for exactly 2400 cycles, with 2400 writes of 16'h0F20 covering {r,c}, r<30, c<80.
  - Then busy=0, in_ready=1, cursor=0,0.
- Send 'A' (0x41) at cursor 0,0:
  - one write, addr 12'h000, data 16'h0F41;
  - then cursor_col=1.
- Send 'B' while cpu_wr=1 for 3 consecutive cycles with addr 12'h085, data 16'h1234:
  - the three CPU writes appear first, in order;
  - the 'B' write follows in the next free cycle;
  - no write is lost.
- Cursor at row 29, col 79, send 'Z':
  - write to {29,79};
  - then CLEAR_LINE writes row 0 cols 0..79;
  - cursor ends at 0,0.
- Send 0x08 at col 0: no write. Then 'x', 0x08: the second write is 16'h0F20 at col 0, and the cursor ends at col 0.
- Send 0x0C mid-screen: 2400 clear writes, then cursor 0,0. Assert reset during that sweep: outputs go to their reset values immediately and the sweep restarts from {0,0}.

Source files
------------

// File: rtl/text_console_ctrl.sv
// Text console sequencer: arbitrates CPU and terminal-byte writes onto one display write port.
// Optional TEXT_CONSOLE_TAB_EN: 0x09 advances the cursor to the next multiple-of-8 column.
module text_console_ctrl #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter logic [7:0] ATTR = 8'h0F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_wr,
  input  logic [11:0] cpu_addr,
  input  logic [15:0] cpu_data,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        dsp_wr,
  output logic [11:0] dsp_addr,
  output logic [15:0] dsp_data,
  output logic [4:0]  cursor_row,
  output logic [6:0]  cursor_col,
  output logic        busy
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {IDLE, PUT, CLEAR_ALL, CLEAR_LINE} state_t;

  state_t      state;
  logic [4:0]  sweepRow;
  logic [6:0]  sweepCol;
  logic [11:0] putAddr;
  logic [7:0]  putChar;
  logic        putAdv;

  logic        pendValid, grant, accept, nlClear;
  logic [11:0] pendAddr;
  logic [15:0] pendData;
  logic [4:0]  nlRow;

  always_comb begin
    pendValid = (state != IDLE);
    pendAddr  = putAddr;
    pendData  = {ATTR, putChar};
    case (state)
      CLEAR_ALL:  begin pendAddr = {sweepRow, sweepCol};   pendData = {ATTR, 8'h20}; end
      CLEAR_LINE: begin pendAddr = {cursor_row, sweepCol}; pendData = {ATTR, 8'h20}; end
      default: ;
    endcase
    grant   = pendValid & ~cpu_wr;
    accept  = in_valid & in_ready;
    // A newline on the bottom row wraps to row 0, which must be blanked first.
    nlClear = (cursor_row == LAST_ROW);
    nlRow   = nlClear ? 5'd0 : cursor_row + 5'd1;
  end

`ifdef TEXT_CONSOLE_TAB_EN
  logic [7:0] tabCol;
  assign tabCol = {1'b0, cursor_col[6:3], 3'b000} + 8'd8;
`endif

  // CPU always wins the port; the FSM's pending write simply repeats until granted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dsp_wr   <= 1'b0;
      dsp_addr <= '0;
      dsp_data <= '0;
    end else begin
      dsp_wr   <= cpu_wr | pendValid;
      dsp_addr <= cpu_wr ? cpu_addr : pendAddr;
      dsp_data <= cpu_wr ? cpu_data : pendData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLEAR_ALL;
      sweepRow   <= '0;
      sweepCol   <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b1;
      putAddr    <= '0;
      putChar    <= '0;
      putAdv     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (in_data >= 8'h20 && in_data <= 8'h7E) begin
              state   <= PUT;
              putAddr <= {cursor_row, cursor_col};
              putChar <= in_data;
              putAdv  <= 1'b1;
            end else if (in_data == 8'h0D) begin
              cursor_col <= '0;
            end else if (in_data == 8'h0A) begin
              cursor_col <= '0;
              cursor_row <= nlRow;
              sweepCol   <= '0;
              if (nlClear) state <= CLEAR_LINE;
            end else if (in_data == 8'h08) begin
              if (cursor_col != 7'd0) begin
                cursor_col <= cursor_col - 7'd1;
                putAddr    <= {cursor_row, cursor_col - 7'd1};
                putChar    <= 8'h20;
                putAdv     <= 1'b0;
                state      <= PUT;
              end
            end else if (in_data == 8'h0C) begin
              state    <= CLEAR_ALL;
              sweepRow <= '0;
              sweepCol <= '0;
              busy     <= 1'b1;
`ifdef TEXT_CONSOLE_TAB_EN
            end else if (in_data == 8'h09) begin
              if (tabCol >= 8'(COLS)) begin
                cursor_col <= '0;
                cursor_row <= nlRow;
                sweepCol   <= '0;
                if (nlClear) state <= CLEAR_LINE;
              end else begin
                cursor_col <= tabCol[6:0];
              end
`endif
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        PUT: begin
          if (grant) begin
            state    <= IDLE;
            in_ready <= 1'b1;
            if (putAdv) begin
              if (cursor_col == LAST_COL) begin
                cursor_col <= '0;
                cursor_row <= nlRow;
                sweepCol   <= '0;
                if (nlClear) begin
                  state    <= CLEAR_LINE;
                  in_ready <= 1'b0;
                end
              end else begin
                cursor_col <= cursor_col + 7'd1;
              end
            end
          end
        end
        CLEAR_LINE: begin
          if (grant) begin
            if (sweepCol == LAST_COL) begin
              state    <= IDLE;
              in_ready <= 1'b1;
            end else begin
              sweepCol <= sweepCol + 7'd1;
            end
          end
        end
        CLEAR_ALL: begin
          if (grant) begin
            if (sweepCol == LAST_COL) begin
              sweepCol <= '0;
              if (sweepRow == LAST_ROW) begin
                state      <= IDLE;
                in_ready   <= 1'b1;
                busy       <= 1'b0;
                cursor_row <= '0;
                cursor_col <= '0;
              end else begin
                sweepRow <= sweepRow + 5'd1;
              end
            end else begin
              sweepCol <= sweepCol + 7'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Scoreboard bench for text_console_ctrl: byte-level text model predicts display writes and cursor.
module tb_text_console_ctrl;
  localparam int COLS = 80, ROWS = 30;

  logic clk = 0, reset = 1;
  logic cpu_wr = 0;
  logic [11:0] cpu_addr = 0;
  logic [15:0] cpu_data = 0;
  logic in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, dsp_wr, busy;
  logic [11:0] dsp_addr;
  logic [15:0] dsp_data;
  logic [4:0] cursor_row;
  logic [6:0] cursor_col;

  text_console_ctrl dut (
    .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .dsp_wr(dsp_wr),
    .dsp_addr(dsp_addr), .dsp_data(dsp_data), .cursor_row(cursor_row),
    .cursor_col(cursor_col), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [27:0] conQ[$];
  logic [27:0] cpuQ[$];
  int mRow = 0, mCol = 0;
  bit cpuRun = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] wr(input int r, input int c, input logic [7:0] ch);
    wr = {5'(r), 7'(c), 8'h0F, ch};
  endfunction

  function automatic void newline();
    mCol = 0;
    if (mRow < ROWS - 1) mRow++;
    else begin
      mRow = 0;
      for (int c = 0; c < COLS; c++) conQ.push_back(wr(0, c, 8'h20));
    end
  endfunction

  function automatic void pushClearAll();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) conQ.push_back(wr(r, c, 8'h20));
  endfunction

  function automatic void model(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      conQ.push_back(wr(mRow, mCol, b));
      mCol++;
      if (mCol == COLS) newline();
    end else if (b == 8'h0D) mCol = 0;
    else if (b == 8'h0A) newline();
    else if (b == 8'h08) begin
      if (mCol > 0) begin mCol--; conQ.push_back(wr(mRow, mCol, 8'h20)); end
    end else if (b == 8'h0C) begin
      pushClearAll();
      mRow = 0; mCol = 0;
    end
`ifdef TEXT_CONSOLE_TAB_EN
    else if (b == 8'h09) begin
      if ((mCol / 8 + 1) * 8 >= COLS) newline();
      else mCol = (mCol / 8 + 1) * 8;
    end
`endif
  endfunction

  // Monitor: a CPU strobe must show up on the very next cycle; anything else is console traffic.
  initial begin
    bit seen;
    logic [27:0] e;
    forever begin
      @(posedge clk);
      seen = cpu_wr;
      @(negedge clk);
      if (seen) begin
        chk("cpu_wr_latency", dsp_wr, 1);
        e = (cpuQ.size() > 0) ? cpuQ.pop_front() : 28'hFFFFFFF;
        chk("cpu_write", {dsp_addr, dsp_data}, e);
      end else if (dsp_wr) begin
        e = (conQ.size() > 0) ? conQ.pop_front() : 28'hFFFFFFF;
        chk("con_write", {dsp_addr, dsp_data}, e);
      end
    end
  end

  task automatic cpuWrites(input int n, input bit rnd, input logic [11:0] a, input logic [15:0] d);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (!rnd || $urandom_range(0, 3) == 0) begin
        cpu_wr = 1;
        cpu_addr = rnd ? 12'($urandom) : a;
        cpu_data = rnd ? 16'($urandom) : d;
        cpuQ.push_back({cpu_addr, cpu_data});
      end else cpu_wr = 0;
    end
    @(negedge clk);
    cpu_wr = 0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1; in_data = b;
    while (!in_ready && n < 20000) begin @(negedge clk); n++; end
    if (n >= 20000) chk("accept_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 0;
    model(b);
  endtask

  task automatic waitIdle();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20000) begin @(negedge clk); n++; end
    chk("idle_timeout", 32'(n < 20000), 1);
    @(negedge clk);
    chk("conq_drained", conQ.size(), 0);
    chk("cursor", {cursor_row, cursor_col}, {5'(mRow), 7'(mCol)});
  endtask

  // Release reset just after an edge and measure how long the power-on/abort sweep keeps busy high.
  task automatic releaseAndSweep();
    int n = 0;
    @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    while (busy && n < 3000) begin n++; @(negedge clk); end
    chk("busy_cycles", n, ROWS * COLS);
    chk("ready_after_sweep", in_ready, 1);
    @(negedge clk);
    chk("sweep_drained", conQ.size(), 0);
    chk("cursor_home", {cursor_row, cursor_col}, 12'h000);
  endtask

  task automatic checkResetValues();
    chk("rst_dsp_wr", dsp_wr, 0);
    chk("rst_dsp_addr", dsp_addr, 0);
    chk("rst_dsp_data", dsp_data, 0);
    chk("rst_cursor", {cursor_row, cursor_col}, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 1);
  endtask

  initial begin
    logic [7:0] b;
    int r;
    repeat (3) @(negedge clk);
    checkResetValues();
    mRow = 0; mCol = 0;
    pushClearAll();
    releaseAndSweep();

    // 'A' at home
    sendByte(8'h41); waitIdle();
    chk("col_after_A", cursor_col, 1);

    // 'B' contending with three back-to-back CPU writes
    fork
      sendByte(8'h42);
      cpuWrites(3, 0, 12'h085, 16'h1234);
    join
    waitIdle();
    chk("cpuq_drained", cpuQ.size(), 0);

    // Walk to the bottom-right corner and wrap
    sendByte(8'h0D);
    for (int i = 0; i < ROWS - 1; i++) sendByte(8'h0A);
    for (int i = 0; i < COLS - 1; i++) sendByte(8'($urandom_range(8'h21, 8'h7E)));
    waitIdle();
    chk("corner", {cursor_row, cursor_col}, {5'd29, 7'd79});
    sendByte(8'h5A); waitIdle();
    chk("wrap_home", {cursor_row, cursor_col}, 12'h000);

    // Backspace at column 0, then overwrite
    sendByte(8'h08); waitIdle();
    sendByte(8'h78); sendByte(8'h08); waitIdle();
    chk("bs_col", cursor_col, 0);

    // Clear from mid-screen
    sendByte(8'h0A); sendByte(8'h0A); sendByte(8'h41); sendByte(8'h42);
    waitIdle();
    sendByte(8'h0C); waitIdle();

    // Reset in the middle of a sweep
    sendByte(8'h0C);
    repeat (300) @(negedge clk);
    #2 reset = 1;
    #1 checkResetValues();
    conQ.delete();
    mRow = 0; mCol = 0;
    pushClearAll();
    repeat (2) @(negedge clk);
    releaseAndSweep();

    // Random bytes under random CPU traffic
    cpuRun = 1;
    fork
      begin
        while (cpuRun) cpuWrites(1, 1, 12'h0, 16'h0);
      end
      begin
        for (int i = 0; i < 250; i++) begin
          r = $urandom_range(0, 99);
          if (r < 60) b = 8'($urandom_range(8'h20, 8'h7E));
          else if (r < 72) b = 8'h0A;
          else if (r < 77) b = 8'h0D;
          else if (r < 85) b = 8'h08;
          else if (r < 86) b = 8'h0C;
          else if (r < 92) b = 8'h09;
          else b = 8'($urandom);
          sendByte(b);
          waitIdle();
        end
        cpuRun = 0;
      end
    join
    repeat (3) @(negedge clk);
    chk("final_cpuq", cpuQ.size(), 0);
    chk("final_conq", conQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
